// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 BFM types: response/QoS mode encodings, write-scheduler limits and entry layout.
package axi4_globals_pkg;

  typedef enum logic [1:0] {
    RESP_IN_ORDER_STRICT  = 2'b00,
    RESP_IN_ORDER         = 2'b01,
    RESP_OUT_OF_ORDER     = 2'b10,
    RESP_OUT_OF_ORDER_ALT = 2'b11
  } response_mode_e;

  typedef enum logic [1:0] {
    QOS_MODE_DISABLE     = 2'b00,
    QOS_MODE_DISABLE_ALT = 2'b01,
    QOS_MODE_ENABLE      = 2'b10,
    QOS_MODE_ENABLE_ALT  = 2'b11
  } qos_mode_e;

  localparam int WR_SCHED_MAX_DEPTH = 64;
  localparam int ID_WIDTH_MAX       = 16;
  localparam int QOS_WIDTH_MAX      = 8;
  localparam int RESP_WIDTH_MAX     = 4;

  typedef struct packed {
    logic [ID_WIDTH_MAX-1:0]   id;
    logic [QOS_WIDTH_MAX-1:0]  qos;
    logic [RESP_WIDTH_MAX-1:0] resp;
    logic                      done;
    logic                      issued;
  } axi4_wr_sched_entry_s;

  function automatic logic is_out_of_order(response_mode_e m);
    return m[1];
  endfunction

  function automatic logic is_qos_enabled(qos_mode_e m);
    return m[1];
  endfunction

endpackage

// File: rtl/axi4_wr_resp_arbiter.sv
// Combinational B-response picker over the age-ordered queue (slot 0 oldest).
// An entry is eligible when done, not yet issued, and no older valid entry shares its id.
module axi4_wr_resp_arbiter
  import axi4_globals_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  axi4_wr_sched_entry_s entries [DEPTH],
  input  logic [DEPTH-1:0]     ent_vld,
  input  logic                 ooo_en,
  input  logic                 qos_en,
  output logic                 sel_vld,
  output logic [IDX_W-1:0]     sel_idx
);

  logic [DEPTH-1:0]         elig;
  logic [QOS_WIDTH_MAX-1:0] best_qos;

  always_comb begin
    elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = ent_vld[i] && entries[i].done && !entries[i].issued;
      for (int j = 0; j < i; j++) begin
        if (ent_vld[j] && (entries[j].id == entries[i].id)) elig[i] = 1'b0;
      end
    end
    if (!ooo_en) elig[DEPTH-1:1] = '0;
  end

  // Strict '>' keeps the oldest on QoS ties; without QoS every hit overrides, so the youngest wins.
  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    best_qos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i] && (!qos_en || !sel_vld || (entries[i].qos > best_qos))) begin
        sel_vld  = 1'b1;
        sel_idx  = IDX_W'(i);
        best_qos = entries[i].qos;
      end
    end
  end

endmodule

// File: rtl/axi4_wr_resp_scheduler.sv
// Slave-side write-response scheduler: tracks outstanding AW..B transactions in a compacting
// age-ordered queue and issues one B at a time, in order or reordered by QoS / youngest-first.
module axi4_wr_resp_scheduler
  import axi4_globals_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int QOS_WIDTH  = 4,
  parameter int DEPTH      = 16,
  parameter int RESP_WIDTH = 2
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [1:0]              resp_mode,
  input  logic [1:0]              qos_mode,
  input  logic                    aw_valid,
  output logic                    aw_ready,
  input  logic [ID_WIDTH-1:0]     aw_id,
  input  logic [QOS_WIDTH-1:0]    aw_qos,
  input  logic                    w_done,
  input  logic [RESP_WIDTH-1:0]   w_resp,
  output logic                    b_valid,
  input  logic                    b_ready,
  output logic [ID_WIDTH-1:0]     b_id,
  output logic [RESP_WIDTH-1:0]   b_resp,
  output logic [$clog2(DEPTH):0]  outstanding,
  output logic                    w_orphan_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  axi4_wr_sched_entry_s ent_q [DEPTH];
  axi4_wr_sched_entry_s ent_d [DEPTH];
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic                  b_vld_q, b_vld_d;
  logic [ID_WIDTH-1:0]   b_id_q, b_id_d;
  logic [RESP_WIDTH-1:0] b_resp_q, b_resp_d;
  logic [IDX_W-1:0]      b_idx_q, b_idx_d;
  logic                  orphan_q, orphan_d;

  logic [DEPTH-1:0] ent_vld;
  logic             sel_vld;
  logic [IDX_W-1:0] sel_idx;
  logic             aw_fire, b_rm, cmp_found;

  assign aw_ready = (occ_q < CNT_W'(DEPTH));
  assign aw_fire  = aw_valid && aw_ready;
  assign b_rm     = b_vld_q && b_ready;

  always_comb begin
    ent_vld = '0;
    for (int i = 0; i < DEPTH; i++) ent_vld[i] = (CNT_W'(i) < occ_q);
  end

  axi4_wr_resp_arbiter #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_arb (
    .entries (ent_q),
    .ent_vld (ent_vld),
    .ooo_en  (is_out_of_order(response_mode_e'(resp_mode))),
    .qos_en  (is_qos_enabled(qos_mode_e'(qos_mode))),
    .sel_vld (sel_vld),
    .sel_idx (sel_idx)
  );

  // Order matters: compaction first, then append at the post-removal tail, then completion.
  always_comb begin
    ent_d     = ent_q;
    occ_d     = occ_q;
    b_vld_d   = b_vld_q;
    b_id_d    = b_id_q;
    b_resp_d  = b_resp_q;
    b_idx_d   = b_idx_q;
    orphan_d  = orphan_q;
    cmp_found = 1'b0;

    if (b_rm) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= b_idx_q) ent_d[i] = ent_q[i+1];
      end
      ent_d[DEPTH-1] = '0;
      occ_d          = occ_q - CNT_W'(1);
      b_vld_d        = 1'b0;
    end

    if (aw_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == occ_d) begin
          ent_d[i] = '{id: ID_WIDTH_MAX'(aw_id), qos: QOS_WIDTH_MAX'(aw_qos),
                       resp: '0, done: 1'b0, issued: 1'b0};
        end
      end
      occ_d = occ_d + CNT_W'(1);
    end

    if (w_done) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!cmp_found && (CNT_W'(i) < occ_d) && !ent_d[i].done) begin
          ent_d[i].done = 1'b1;
          ent_d[i].resp = RESP_WIDTH_MAX'(w_resp);
          cmp_found     = 1'b1;
        end
      end
      if (!cmp_found) orphan_d = 1'b1;
    end

    // Selection only while idle; indices are stable since no removal happens this cycle.
    if (!b_vld_q && sel_vld) begin
      ent_d[sel_idx].issued = 1'b1;
      b_vld_d  = 1'b1;
      b_idx_d  = sel_idx;
      b_id_d   = ent_q[sel_idx].id[ID_WIDTH-1:0];
      b_resp_d = ent_q[sel_idx].resp[RESP_WIDTH-1:0];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      occ_q    <= '0;
      b_vld_q  <= 1'b0;
      b_id_q   <= '0;
      b_resp_q <= '0;
      b_idx_q  <= '0;
      orphan_q <= 1'b0;
    end else begin
      ent_q    <= ent_d;
      occ_q    <= occ_d;
      b_vld_q  <= b_vld_d;
      b_id_q   <= b_id_d;
      b_resp_q <= b_resp_d;
      b_idx_q  <= b_idx_d;
      orphan_q <= orphan_d;
    end
  end

  assign b_valid      = b_vld_q;
  assign b_id         = b_id_q;
  assign b_resp       = b_resp_q;
  assign outstanding  = occ_q;
  assign w_orphan_err = orphan_q;

endmodule
